// File: rtl/mc_fetch_datapath.sv
// Fetch/memory datapath for the multi-cycle MIPS core: PC, IR, MDR, EPC, Cause
// and the req/ack memory handshake that stalls the microsequencer.
//
// state | meaning
// IDLE  | no access in flight; latch address/data/direction when an access starts
// REQ   | mem_req asserted, waiting for mem_ack
// DONE  | access complete; stall released so the control unit advances this cycle
module mc_fetch_datapath #(
    parameter int          DATA_W     = 32,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR = 32'h8000_0180
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              IorD,
    input  logic              memRd,
    input  logic              memWr,
    input  logic              irWr,
    input  logic              PCWr,
    input  logic              PCWrCond,
    input  logic [2:0]        PCSrc,
    input  logic              EPC,
    input  logic              cause_write,
    input  logic              int_cause,
    input  logic [31:0]       alu_result,
    input  logic [31:0]       alu_out,
    input  logic [31:0]       reg_a,
    input  logic [DATA_W-1:0] reg_b,
    input  logic              zero,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              mem_req,
    output logic              mem_we,
    output logic [31:0]       mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              stall,
    output logic [31:0]       pc,
    output logic [DATA_W-1:0] ir,
    output logic [DATA_W-1:0] mdr,
    output logic [31:0]       epc_q,
    output logic [31:0]       cause_q,
    output logic [5:0]        opcode,
    output logic [5:0]        funct
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } memState_t;

    memState_t   state;
    memState_t   nextState;
    logic        access;
    logic        pcEn;
    logic [31:0] pcNext;
    logic [4:0]  excCode;

    assign access  = memRd | memWr;
    assign stall   = access & (state != DONE);
    assign mem_req = (state == REQ);
    assign pcEn    = PCWr | (PCWrCond & zero);
    assign excCode = int_cause ? 5'd12 : 5'd10;
    assign opcode  = ir[31:26];
    assign funct   = ir[5:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (access) nextState = REQ;
            REQ:     if (mem_ack) nextState = DONE;
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        pcNext = pc;
        case (PCSrc)
            3'd0:    pcNext = alu_result;
            3'd1:    pcNext = alu_out;
            3'd2:    pcNext = {pc[31:28], ir[25:0], 2'b00};
            3'd3:    pcNext = reg_a;
            3'd4:    pcNext = EXC_VECTOR;
            default: pcNext = pc;
        endcase
    end

    // Direction comes from the latched mem_we so memWr wins over memRd.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
            mdr       <= '0;
            ir        <= '0;
        end else begin
            if (state == IDLE && access) begin
                mem_addr  <= IorD ? alu_out : pc;
                mem_wdata <= reg_b;
                mem_we    <= memWr;
            end
            if (state == REQ && mem_ack && !mem_we) begin
                mdr <= mem_rdata;
            end
            if (state == DONE && irWr && memRd && !mem_we) begin
                ir <= mdr;
            end
        end
    end

    // Architectural updates use pre-edge pc, so PC/EPC/Cause writes are order-independent.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc      <= RESET_PC;
            epc_q   <= '0;
            cause_q <= '0;
        end else if (!stall) begin
            if (pcEn) begin
                pc <= pcNext;
            end
            if (EPC) begin
                epc_q <= pc - 32'd4;
            end
            if (cause_write) begin
                cause_q <= {25'd0, excCode, 2'b00};
            end
        end
    end

endmodule

// File: tb/tb_mc_fetch_datapath.sv
// Scoreboard bench for mc_fetch_datapath: memory accesses are checked by a
// monitor at the DONE cycle, architectural registers by directed checks.
module tb_mc_fetch_datapath;

    logic        clk;
    logic        rst_n;
    logic        IorD, memRd, memWr, irWr, PCWr, PCWrCond;
    logic [2:0]  PCSrc;
    logic        EPC, cause_write, int_cause;
    logic [31:0] alu_result, alu_out, reg_a, reg_b;
    logic        zero;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        mem_req, mem_we, stall;
    logic [31:0] mem_addr, mem_wdata, pc, ir, mdr, epc_q, cause_q;
    logic [5:0]  opcode, funct;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        int          stallCycles;
        logic [31:0] mdrVal;
    } txn_t;

    txn_t sbQ[$];
    int   checks   = 0;
    int   failures = 0;

    mc_fetch_datapath dut (
        .clk(clk), .rst_n(rst_n), .IorD(IorD), .memRd(memRd), .memWr(memWr),
        .irWr(irWr), .PCWr(PCWr), .PCWrCond(PCWrCond), .PCSrc(PCSrc), .EPC(EPC),
        .cause_write(cause_write), .int_cause(int_cause), .alu_result(alu_result),
        .alu_out(alu_out), .reg_a(reg_a), .reg_b(reg_b), .zero(zero),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .stall(stall), .pc(pc), .ir(ir),
        .mdr(mdr), .epc_q(epc_q), .cause_q(cause_q), .opcode(opcode), .funct(funct)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic clearCtl();
        IorD = 0; memRd = 0; memWr = 0; irWr = 0; PCWr = 0; PCWrCond = 0;
        PCSrc = 3'd0; EPC = 0; cause_write = 0; int_cause = 0; zero = 0; mem_ack = 0;
    endtask

    task automatic pushExp(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                           input int stallCycles, input logic [31:0] mdrVal);
        txn_t t;
        t.addr = addr; t.we = we; t.wdata = wdata; t.stallCycles = stallCycles; t.mdrVal = mdrVal;
        sbQ.push_back(t);
    endtask

    // Called at posedge+1 with strobes already set; ends at posedge+1 after DONE.
    task automatic memStep(input int delay, input logic [31:0] rdata);
        @(posedge clk); #1;
        repeat (delay) begin @(posedge clk); #1; end
        mem_rdata = rdata;
        mem_ack   = 1;
        @(posedge clk); #1;
        mem_ack = 0;
        @(posedge clk); #1;
        clearCtl();
    endtask

    task automatic pulse();
        @(posedge clk); #1;
        clearCtl();
    endtask

    // Monitor: counts stall cycles per access, checks the access when stall releases.
    initial begin
        int   stallRun;
        txn_t e;
        stallRun = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stallRun = 0;
            end else if (stall) begin
                stallRun++;
            end else if (stallRun > 0) begin
                if (sbQ.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_access actual addr=%h required none", mem_addr);
                end else begin
                    e = sbQ.pop_front();
                    chk("txn_addr", mem_addr, e.addr);
                    chk("txn_we", {31'd0, mem_we}, {31'd0, e.we});
                    chk("txn_wdata", mem_wdata, e.wdata);
                    chk("txn_stall_cycles", stallRun, e.stallCycles);
                    chk("txn_mdr", mdr, e.mdrVal);
                    chk("txn_req_dropped", {31'd0, mem_req}, 32'd0);
                end
                stallRun = 0;
            end
        end
    end

    initial begin
        clearCtl();
        alu_result = 0; alu_out = 0; reg_a = 0; reg_b = 0; mem_rdata = 0;
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;

        chk("rst_pc", pc, 32'h0);
        chk("rst_ir", ir, 32'h0);
        chk("rst_mdr", mdr, 32'h0);
        chk("rst_epc", epc_q, 32'h0);
        chk("rst_cause", cause_q, 32'h0);
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_stall", {31'd0, stall}, 32'd0);

        // Zero-wait fetch
        memRd = 1; irWr = 1; PCWr = 1; PCSrc = 3'd0; alu_result = 32'h4; reg_b = 32'h0;
        pushExp(32'h0, 1'b0, 32'h0, 2, 32'h0000_0020);
        memStep(0, 32'h0000_0020);
        chk("fetch_pc", pc, 32'h4);
        chk("fetch_ir", ir, 32'h20);
        chk("fetch_opcode", {26'd0, opcode}, 32'd0);
        chk("fetch_funct", {26'd0, funct}, 32'd32);

        // Load with three wait cycles
        memRd = 1; IorD = 1; alu_out = 32'h100; reg_b = 32'h5555_0000;
        pushExp(32'h100, 1'b0, 32'h5555_0000, 5, 32'h1234_5678);
        memStep(3, 32'h1234_5678);
        chk("lw_pc", pc, 32'h4);
        chk("lw_ir", ir, 32'h20);

        // Store
        memWr = 1; IorD = 1; alu_out = 32'h40; reg_b = 32'hDEAD_BEEF;
        pushExp(32'h40, 1'b1, 32'hDEAD_BEEF, 3, 32'h1234_5678);
        memStep(1, 32'hFFFF_FFFF);
        chk("sw_mdr", mdr, 32'h1234_5678);

        // memRd and memWr together: write wins, no MDR/IR load
        memRd = 1; memWr = 1; irWr = 1; IorD = 0; reg_b = 32'hAA;
        pushExp(32'h4, 1'b1, 32'hAA, 2, 32'h1234_5678);
        memStep(0, 32'h0BAD_0BAD);
        chk("rdwr_ir", ir, 32'h20);

        // Ack outside REQ is ignored
        mem_ack = 1; mem_rdata = 32'h7777;
        pulse();
        chk("stray_ack_mdr", mdr, 32'h1234_5678);
        chk("stray_ack_req", {31'd0, mem_req}, 32'd0);

        // Conditional branch
        PCWrCond = 1; PCSrc = 3'd1; alu_out = 32'h80; zero = 0;
        pulse();
        chk("beq_not_taken", pc, 32'h4);
        PCWrCond = 1; PCSrc = 3'd1; alu_out = 32'h80; zero = 1;
        pulse();
        chk("beq_taken", pc, 32'h80);

        // Fetch a jump and take it
        memRd = 1; irWr = 1; PCWr = 1; PCSrc = 3'd0; alu_result = 32'h84; reg_b = 32'h0;
        pushExp(32'h80, 1'b0, 32'h0, 2, 32'h0800_0010);
        memStep(0, 32'h0800_0010);
        chk("jfetch_pc", pc, 32'h84);
        chk("jfetch_opcode", {26'd0, opcode}, 32'd2);
        chk("jfetch_funct", {26'd0, funct}, 32'h10);
        PCWr = 1; PCSrc = 3'd2;
        pulse();
        chk("jump_pc", pc, 32'h40);

        PCWr = 1; PCSrc = 3'd5; alu_result = 32'h999;
        pulse();
        chk("pcsrc5_hold", pc, 32'h40);

        PCWr = 1; PCSrc = 3'd0; alu_result = 32'h24;
        pulse();
        chk("set_pc", pc, 32'h24);

        // Exception entry, overflow then undefined instruction
        EPC = 1; cause_write = 1; int_cause = 1; PCWr = 1; PCSrc = 3'd4;
        pulse();
        chk("exc_ov_epc", epc_q, 32'h20);
        chk("exc_ov_cause", cause_q, 32'h30);
        chk("exc_ov_pc", pc, 32'h8000_0180);
        EPC = 1; cause_write = 1; int_cause = 0; PCWr = 1; PCSrc = 3'd4;
        pulse();
        chk("exc_ri_epc", epc_q, 32'h8000_017C);
        chk("exc_ri_cause", cause_q, 32'h28);
        chk("exc_ri_pc", pc, 32'h8000_0180);

        PCWr = 1; PCSrc = 3'd3; reg_a = 32'h2000;
        pulse();
        chk("jr_pc", pc, 32'h2000);

        // Strobes asserted while stalled must not write anything
        memRd = 1; IorD = 0; irWr = 1; PCWr = 1; PCSrc = 3'd1; alu_out = 32'h500;
        EPC = 1; cause_write = 1; int_cause = 1; reg_b = 32'h0;
        pushExp(32'h2000, 1'b0, 32'h0, 3, 32'hCAFE_0001);
        @(posedge clk); #1;
        chk("gate_idle_pc", pc, 32'h2000);
        @(posedge clk); #1;
        chk("gate_req_pc", pc, 32'h2000);
        chk("gate_req_epc", epc_q, 32'h8000_017C);
        chk("gate_req_cause", cause_q, 32'h28);
        irWr = 0; PCWr = 0; EPC = 0; cause_write = 0;
        mem_rdata = 32'hCAFE_0001; mem_ack = 1;
        @(posedge clk); #1;
        mem_ack = 0;
        @(posedge clk); #1;
        clearCtl();
        chk("gate_ir", ir, 32'h0800_0010);
        chk("gate_pc", pc, 32'h2000);

        // Asynchronous reset in the middle of REQ
        memRd = 1; IorD = 1; alu_out = 32'h300;
        @(posedge clk); #1;
        chk("mid_req_asserted", {31'd0, mem_req}, 32'd1);
        #2 rst_n = 0;
        #1;
        chk("mid_req_dropped", {31'd0, mem_req}, 32'd0);
        clearCtl();
        @(posedge clk); #1;
        rst_n = 1;
        chk("rst2_pc", pc, 32'h0);
        chk("rst2_ir", ir, 32'h0);
        chk("rst2_mdr", mdr, 32'h0);
        chk("rst2_epc", epc_q, 32'h0);
        chk("rst2_cause", cause_q, 32'h0);
        @(posedge clk); #1;
        chk("rst2_req_idle", {31'd0, mem_req}, 32'd0);
        chk("rst2_stall", {31'd0, stall}, 32'd0);

        @(posedge clk); #1;
        chk("scoreboard_drained", sbQ.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
